rx_fcs_checker: RTL and testbench
=================================

# rx_fcs_checker

Receive-side counterpart of the transmit CRC generator. Accepts an Ethernet frame as a byte stream (destination address through the 4-byte FCS), runs the IEEE 802.3 CRC-32 over every byte, strips the FCS from the forwarded stream, and reports a per-frame good/bad verdict. Sits between the RX byte deserialiser and the receive FIFO/MAC filter.

## Interface
- `POLYNOMIAL`, 32'h04C11DB7: CRC-32 generator, normal form; used bit-reflected internally.
- `SEED`, 32'hFFFFFFFF: CRC register value at start of frame.
- `RESIDUE`, 32'hDEBB20E3: register value after a correct frame, including its FCS bytes, has been absorbed.
- `MIN_LENGTH`, 64: minimum frame length in bytes, FCS included.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  8  received byte; bit 0 is first on the wire.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_sof`  in  1  first byte of frame; qualified by `in_valid`.
- `in_eof`  in  1  last byte of frame (last FCS byte); qualified by `in_valid`.
- `out_data`  out  8  forwarded payload byte.
- `out_valid`  out  1  `out_data` valid.
- `out_sof`  out  1  first payload byte.
- `out_eof`  out  1  last payload byte.
- `frame_done`  out  1  one-cycle status strobe.
- `frame_good`  out  1  CRC ok and length ≥ `MIN_LENGTH`; valid with `frame_done`.
- `crc_error`  out  1  residue mismatch; valid with `frame_done`.
- `runt`  out  1  length < `MIN_LENGTH`; valid with `frame_done`.
- `aborted`  out  1  frame ended by a new `in_sof` before `in_eof`; valid with `frame_done`.
- `frame_length`  out  16  bytes received, FCS included, saturating at 16'hFFFF; valid with `frame_done`.

## Operation
- FSM states:
  - IDLE: bytes without `in_sof` are ignored.
  - ACTIVE: entered on `in_valid & in_sof`.
- CRC:
  - On SOF the CRC register loads `SEED`, then absorbs the byte LSB-first with the reflected polynomial 0xEDB88320.
  - Every later valid byte updates the register the same way.
- Delay line:
  - A 4-entry byte shift register plus fill count (0–4) holds the last four received bytes.
  - When a valid byte arrives and the line already holds 4 bytes, the oldest byte is emitted.
  - The line therefore never emits the final 4 bytes, i.e. the FCS.
  - `out_sof` marks the first emitted byte of the frame.
  - `out_eof` is set on the byte emitted in the `in_eof` cycle.
- End of frame (`in_eof`):
  - Compare the updated CRC (including this byte) against `RESIDUE`; set `crc_error` on mismatch.
  - Set `runt` if length < `MIN_LENGTH`.
  - `frame_good` = !`crc_error` & !`runt` & !`aborted`.
  - Clear the delay line; return to IDLE.
- Frames of ≤ 4 bytes emit no payload and no `out_eof`; `frame_done` still fires with `runt`=1.
- A frame with `in_sof` and `in_eof` on the same byte has length 1: runt, no payload.
- `in_sof` while ACTIVE:
  - Strobe `frame_done` with `aborted`=1, `frame_good`=0, `crc_error`=0.
  - Discard the delay line without emitting `out_eof`.
  - Restart the frame on this byte.
- `in_valid` low: no state change, no output.
- `frame_length` stops at 16'hFFFF; the CRC continues to update.

## Timing
- All outputs registered; reset value 0 for every output, including `frame_length`.
- Payload byte k is presented the cycle after byte k+4 is accepted.
- `frame_done` and its status fields appear the cycle after the `in_eof` byte, coincident with the `out_eof` byte.
- The status outputs hold their value until the next `frame_done`.
- `out_valid`, `out_sof`, `out_eof` and `frame_done` are single-cycle strobes.
- Throughput: one byte per cycle, with no backpressure.
- `reset` mid-frame clears the FSM, delay line and CRC. No `frame_done` is issued for the interrupted frame.

## Structure
- Shared `crc_pkg` holds:
  - constants `CRC32_POLY`, `CRC32_SEED`, `CRC32_RESIDUE`;
  - the byte-wide reflected CRC update function, shared with the TX generator.
- One sub-module, `crc32_byte_update`: combinational next-CRC from the current CRC and `in_data`.
- The FSM, delay line and status logic live in the top level.

## Test plan
- With `MIN_LENGTH`=5, feed 13 bytes: 31 32 33 34 35 36 37 38 39, then FCS 26 39 F4 CB.
  - Payload 31..39 out, `out_sof` on 31, `out_eof` on 39.
  - `frame_good`=1, `frame_length`=13.
- Same frame with the FCS byte F4 changed to F5 → `crc_error`=1, `frame_good`=0; payload still forwarded.
- Same good 13-byte frame with `MIN_LENGTH`=64 → `runt`=1, `crc_error`=0, `frame_good`=0.
- 3-byte frame AA BB CC → no `out_valid`, `frame_done` with `runt`=1, `frame_length`=3.
- `in_sof` on byte 7 of an unfinished frame, then a complete good frame →
  - first `frame_done` with `aborted`=1;
  - second `frame_done` with `frame_good`=1.
- `reset` asserted after 6 bytes of a frame, then a good frame → only one `frame_done`, with `frame_good`=1; gaps in `in_valid` do not change the results.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-32 constants, FSM state type and the byte-wide reflected update
package crc_pkg;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic {ST_IDLE, ST_ACTIVE} rx_state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // absorbs one byte LSB-first into a reflected CRC register
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data, input logic [31:0] poly);
        logic [31:0] c;
        logic [31:0] rp;
        rp = reflect32(poly);
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
        return c;
    endfunction
endpackage

// File: rtl/crc32_byte_update.sv
// crc32_byte_update: combinational next-CRC from the current register and one data byte
module crc32_byte_update
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    assign o_crc = crc32_byte(i_crc, i_data, POLY);
endmodule

// File: rtl/rx_fcs_checker.sv
// rx_fcs_checker: checks the Ethernet FCS, strips it from the byte stream and reports a per-frame verdict
module rx_fcs_checker
    import crc_pkg::*;
#(
    parameter logic [31:0] POLYNOMIAL = CRC32_POLY,
    parameter logic [31:0] SEED       = CRC32_SEED,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
    parameter int          MIN_LENGTH = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_good,
    output logic        crc_error,
    output logic        runt,
    output logic        aborted,
    output logic [15:0] frame_length
);
    localparam logic [15:0] MIN_LEN = 16'(MIN_LENGTH);

    rx_state_t   r_state;
    logic [31:0] r_crc;
    logic [31:0] r_dl;
    logic [15:0] r_len;
    logic [31:0] w_crc_next;
    logic [15:0] w_len_inc;
    logic [15:0] w_end_len;
    logic        w_crc_err;
    logic        w_runt;

    crc32_byte_update #(.POLY(POLYNOMIAL)) u_crc (
        .i_crc  (in_sof ? SEED : r_crc),
        .i_data (in_data),
        .o_crc  (w_crc_next)
    );

    assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
    assign w_end_len = in_sof ? 16'd1 : w_len_inc;
    assign w_crc_err = w_crc_next != RESIDUE;
    assign w_runt    = w_end_len < MIN_LEN;

    // frame FSM: CRC accumulation, 4-byte FCS-stripping delay line and end-of-frame status
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_crc        <= '0;
            r_dl         <= '0;
            r_len        <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            frame_done   <= 1'b0;
            frame_good   <= 1'b0;
            crc_error    <= 1'b0;
            runt         <= 1'b0;
            aborted      <= 1'b0;
            frame_length <= '0;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid && (in_sof || r_state == ST_ACTIVE)) begin
                r_crc   <= w_crc_next;
                r_dl    <= {r_dl[23:0], in_data};
                r_len   <= w_end_len;
                r_state <= in_eof ? ST_IDLE : ST_ACTIVE;
                if (in_sof && r_state == ST_ACTIVE) begin
                    frame_done   <= 1'b1;
                    aborted      <= 1'b1;
                    frame_good   <= 1'b0;
                    crc_error    <= 1'b0;
                    runt         <= r_len < MIN_LEN;
                    frame_length <= r_len;
                end
                if (!in_sof && r_len >= 16'd4) begin
                    out_valid <= 1'b1;
                    out_data  <= r_dl[31:24];
                    out_sof   <= r_len == 16'd4;
                    out_eof   <= in_eof;
                end
                if (in_eof) begin
                    frame_done   <= 1'b1;
                    aborted      <= 1'b0;
                    crc_error    <= w_crc_err;
                    runt         <= w_runt;
                    frame_good   <= !w_crc_err && !w_runt;
                    frame_length <= w_end_len;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_fcs_checker.sv
// tb_rx_fcs_checker: directed frames against a queue-based frame model, two MIN_LENGTH settings side by side
module tb_rx_fcs_checker;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  od;
        logic        ov, os, oe, fd, fg, ce, ru, ab;
        logic [15:0] fl;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0]  od[2];
    logic        ov[2], os[2], oe[2], fd[2], fg[2], ce[2], ru[2], ab[2];
    logic [15:0] fl[2];

    int   total = 0;
    int   bad = 0;
    int   mins[2] = '{5, 64};
    exp_t e[2] = '{default: '0};
    exp_t n[2];
    bq_t  q;
    bit   active = 0;

    always #5 clock = ~clock;

    rx_fcs_checker #(.MIN_LENGTH(5)) u5 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .out_data(od[0]), .out_valid(ov[0]), .out_sof(os[0]), .out_eof(oe[0]), .frame_done(fd[0]),
        .frame_good(fg[0]), .crc_error(ce[0]), .runt(ru[0]), .aborted(ab[0]), .frame_length(fl[0])
    );

    rx_fcs_checker #(.MIN_LENGTH(64)) u64 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .out_data(od[1]), .out_valid(ov[1]), .out_sof(os[1]), .out_eof(oe[1]), .frame_done(fd[1]),
        .frame_good(fg[1]), .crc_error(ce[1]), .runt(ru[1]), .aborted(ab[1]), .frame_length(fl[1])
    );

    function automatic void cmp(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, want, $time);
        end
    endfunction

    // wire-order CRC with the normal-form polynomial, returned bit-reversed to the reflected register view
    function automatic logic [31:0] wire_crc(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] r;
        logic fb;
        foreach (b[i]) for (int j = 0; j < 8; j++) begin
            fb = c[31] ^ b[i][j];
            c = {c[30:0], 1'b0};
            if (fb) c ^= 32'h04C11DB7;
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return r;
    endfunction

    function automatic logic [15:0] sat_len(input int l);
        return (l > 65535) ? 16'hFFFF : 16'(l);
    endfunction

    function automatic void close_frame();
        logic crc_bad;
        crc_bad = wire_crc(q) != 32'hDEBB20E3;
        for (int k = 0; k < 2; k++) begin
            n[k].fd = 1; n[k].ab = 0; n[k].fl = sat_len(q.size());
            n[k].ru = q.size() < mins[k]; n[k].ce = crc_bad; n[k].fg = !crc_bad && !n[k].ru;
        end
        q.delete();
        active = 0;
    endfunction

    task automatic step(input logic v, input logic s, input logic eo, input logic [7:0] d, input logic r);
        in_valid = v; in_sof = s; in_eof = eo; in_data = d; reset = r;
        n = e;
        for (int k = 0; k < 2; k++) begin
            n[k].ov = 0; n[k].os = 0; n[k].oe = 0; n[k].fd = 0;
        end
        if (r) begin
            for (int k = 0; k < 2; k++) n[k] = '0;
            q.delete();
            active = 0;
        end else if (v && s) begin
            if (active) for (int k = 0; k < 2; k++) begin
                n[k].fd = 1; n[k].ab = 1; n[k].fg = 0; n[k].ce = 0;
                n[k].fl = sat_len(q.size()); n[k].ru = q.size() < mins[k];
            end
            q.delete();
            q.push_back(d);
            active = 1;
            if (eo) close_frame();
        end else if (v && active) begin
            if (q.size() >= 4) for (int k = 0; k < 2; k++) begin
                n[k].ov = 1; n[k].od = q[q.size()-4]; n[k].os = q.size() == 4; n[k].oe = eo;
            end
            q.push_back(d);
            if (eo) close_frame();
        end
        @(posedge clock);
        #1;
        e = n;
    endtask

    task automatic send(input bq_t b, input bit gaps);
        foreach (b[i]) begin
            step(1, i == 0, i == b.size() - 1, b[i], 0);
            if (gaps) step(0, 0, 0, 8'hEE, 0);
        end
    endtask

    // every cycle, both instances against the model
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(e[k].ov));
            cmp($sformatf("u%0d.out_sof", k), 32'(os[k]), 32'(e[k].os));
            cmp($sformatf("u%0d.out_eof", k), 32'(oe[k]), 32'(e[k].oe));
            cmp($sformatf("u%0d.frame_done", k), 32'(fd[k]), 32'(e[k].fd));
            cmp($sformatf("u%0d.frame_good", k), 32'(fg[k]), 32'(e[k].fg));
            cmp($sformatf("u%0d.crc_error", k), 32'(ce[k]), 32'(e[k].ce));
            cmp($sformatf("u%0d.runt", k), 32'(ru[k]), 32'(e[k].ru));
            cmp($sformatf("u%0d.aborted", k), 32'(ab[k]), 32'(e[k].ab));
            cmp($sformatf("u%0d.frame_length", k), 32'(fl[k]), 32'(e[k].fl));
            if (e[k].ov) cmp($sformatf("u%0d.out_data", k), 32'(od[k]), 32'(e[k].od));
        end
    end

    initial begin
        bq_t good, badf, tiny, pre, chk, big;
        int dones;
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        badf = good;
        badf[11] = 8'hF5;
        tiny = '{8'hAA, 8'hBB, 8'hCC};
        pre  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        chk  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        cmp("model_crc_123456789", ~wire_crc(chk), 32'hCBF43926);
        cmp("model_residue_good", wire_crc(good), 32'hDEBB20E3);

        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        cmp("reset_frame_length", 32'(fl[0]), 32'h0);
        cmp("reset_frame_done", 32'(fd[0]), 32'h0);
        step(1, 0, 0, 8'h77, 0);
        step(1, 0, 1, 8'h78, 0);

        send(good, 0);
        cmp("good_frame_length", 32'(fl[0]), 32'd13);
        cmp("good_frame_good", 32'(fg[0]), 32'd1);
        cmp("good_min64_runt", 32'(ru[1]), 32'd1);
        cmp("good_min64_crc_error", 32'(ce[1]), 32'd0);
        step(0, 0, 0, 8'h00, 0);

        send(badf, 0);
        cmp("bad_crc_error", 32'(ce[0]), 32'd1);
        cmp("bad_frame_good", 32'(fg[0]), 32'd0);
        step(0, 0, 0, 8'h00, 0);

        send(tiny, 0);
        cmp("tiny_runt", 32'(ru[0]), 32'd1);
        cmp("tiny_frame_length", 32'(fl[0]), 32'd3);
        step(1, 1, 1, 8'h42, 0);
        cmp("single_byte_length", 32'(fl[0]), 32'd1);
        cmp("single_byte_runt", 32'(ru[0]), 32'd1);

        foreach (pre[i]) step(1, i == 0, 0, pre[i], 0);
        step(1, 1, 0, good[0], 0);
        cmp("abort_done", 32'(fd[0]), 32'd1);
        cmp("abort_aborted", 32'(ab[0]), 32'd1);
        cmp("abort_length", 32'(fl[0]), 32'd6);
        for (int i = 1; i < good.size(); i++) step(1, 0, i == good.size() - 1, good[i], 0);
        cmp("after_abort_good", 32'(fg[0]), 32'd1);
        cmp("after_abort_aborted", 32'(ab[0]), 32'd0);

        dones = 0;
        foreach (pre[i]) begin
            step(1, i == 0, 0, pre[i], 0);
            dones += fd[0];
            step(0, 0, 0, 8'hEE, 0);
        end
        step(0, 0, 0, 8'h00, 1);
        foreach (good[i]) begin
            step(1, i == 0, i == good.size() - 1, good[i], 0);
            dones += fd[0];
            step(0, 0, 0, 8'hEE, 0);
        end
        cmp("reset_midframe_done_count", 32'(dones), 32'd1);
        cmp("reset_midframe_good", 32'(fg[0]), 32'd1);

        big = {};
        for (int i = 0; i < 65540; i++) big.push_back(8'(i * 7 + 3));
        send(big, 0);
        cmp("saturated_length", 32'(fl[0]), 32'hFFFF);
        cmp("saturated_runt", 32'(ru[1]), 32'd0);

        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
